// File: rtl/tmr_multi_ch_if.sv
// Register-bus interface for tmr_multi_ch.
//   i_wren   : write strobe, one write per cycle
//   i_addr   : [ADDR_W-1:3] channel, [2:0] register
//   i_datain : write data
//   o_rdata  : combinational read data for i_addr
// master = bus host side, slave = timer side.
interface tmr_multi_ch_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 6
);
  logic              i_wren;
  logic [ADDR_W-1:0] i_addr;
  logic [CNT_W-1:0]  i_datain;
  logic [CNT_W-1:0]  o_rdata;

  modport master (output i_wren, i_addr, i_datain, input  o_rdata);
  modport slave  (input  i_wren, i_addr, i_datain, output o_rdata);
endinterface

// File: rtl/tmr_multi_ch.sv
// Multi-channel timer: NUM_CH up-counters with a shared prescaler,
// external-clock and cascade sources, two compares, waveform out, level irq.
// Ports:
//   i_clk_sys : system clock (rising edge)
//   i_rst_n   : synchronous active-low reset
//   bus       : register bus (tmr_multi_ch_if.slave)
//   i_tmci    : asynchronous external count inputs, one per channel
//   o_tmo     : waveform outputs
//   o_irq     : registered level interrupts
module tmr_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  tmr_multi_ch_if.slave     bus,
  input  logic [NUM_CH-1:0] i_tmci,
  output logic [NUM_CH-1:0] o_tmo,
  output logic [NUM_CH-1:0] o_irq
);
  localparam int CH_W = ADDR_W - 3;

  logic [12:0]       r_presc;
  logic [NUM_CH-1:0] w_ovf_pulse;
  logic [CNT_W-1:0]  w_rd_ch [NUM_CH];
  logic [CH_W-1:0]   w_ch;
  logic [2:0]        w_reg;

  assign w_ch  = bus.i_addr[ADDR_W-1:3];
  assign w_reg = bus.i_addr[2:0];

  function automatic logic os_act(input logic [1:0] os, input logic cur);
    case (os)
      2'b01:   os_act = 1'b0;
      2'b10:   os_act = 1'b1;
      2'b11:   os_act = ~cur;
      default: os_act = cur;
    endcase
  endfunction

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) r_presc <= '0;
    else          r_presc <= r_presc + 13'd1;
  end

  // Unmapped channel indices fall through to zero.
  always_comb begin
    bus.o_rdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (w_ch == CH_W'(c)) bus.o_rdata = w_rd_ch[c];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_tcnt, r_tcora, r_tcorb;
    logic [12:0]      r_tcr;
    logic             r_cmfa, r_cmfb, r_ovf, r_tmo, r_irq, r_ovf_pulse;
    logic [2:0]       r_sync;  // [0],[1] synchroniser, [2] previous [1] for edge detect
    logic             w_sel, w_wr_tcnt, w_wr_tcora, w_wr_tcorb, w_wr_tcr, w_wr_tcsr;
    logic             w_casc, w_tick, w_eval, w_match_a, w_match_b, w_clr;
    logic             w_cmfa_set, w_cmfb_set, w_ovf_set, w_tmo_nxt;
    logic [CNT_W-1:0] w_tcnt_nxt, w_rd;
    logic [12:0]      w_tcr_nxt;

    assign w_sel      = bus.i_wren && (w_ch == CH_W'(c));
    assign w_wr_tcnt  = w_sel && (w_reg == 3'd0);
    assign w_wr_tcora = w_sel && (w_reg == 3'd1);
    assign w_wr_tcorb = w_sel && (w_reg == 3'd2);
    assign w_wr_tcr   = w_sel && (w_reg == 3'd3);
    assign w_wr_tcsr  = w_sel && (w_reg == 3'd4);

    if (c == 0) begin : g_casc0
      assign w_casc = 1'b0;
    end else begin : g_casc
      assign w_casc = w_ovf_pulse[c-1];
    end

    always_comb begin
      w_tick = 1'b0;
      case (r_tcr[2:0])
        3'd1: w_tick = r_presc[0];
        3'd2: w_tick = &r_presc[2:0];
        3'd3: w_tick = &r_presc[5:0];
        3'd4: w_tick = &r_presc[9:0];
        3'd5: w_tick = &r_presc;
        3'd6: w_tick = r_sync[1] & ~r_sync[2];
        3'd7: w_tick = w_casc;
        default: w_tick = 1'b0;
      endcase
    end

    // A TCNT write suppresses the whole tick, including match evaluation.
    always_comb begin
      w_match_a  = (r_tcnt == r_tcora);
      w_match_b  = (r_tcnt == r_tcorb);
      w_eval     = w_tick && !w_wr_tcnt;
      w_clr      = ((r_tcr[4:3] == 2'b01) && w_match_a) ||
                   ((r_tcr[4:3] == 2'b10) && w_match_b) ||
                   (r_tcr[5] && w_match_a);
      w_tcnt_nxt = r_tcnt;
      w_tcr_nxt  = r_tcr;
      w_tmo_nxt  = r_tmo;
      w_cmfa_set = 1'b0;
      w_cmfb_set = 1'b0;
      w_ovf_set  = 1'b0;
      if (w_eval) begin
        w_tcnt_nxt = w_clr ? '0 : r_tcnt + CNT_W'(1);
        w_ovf_set  = !w_clr && (&r_tcnt);
        w_cmfa_set = w_match_a;
        w_cmfb_set = w_match_b;
        if (r_tcr[5] && w_match_a) w_tcr_nxt[2:0] = 3'b000;
        if (w_match_b && (r_tcr[12:11] != 2'b00)) w_tmo_nxt = os_act(r_tcr[12:11], r_tmo);
        else if (w_match_a)                       w_tmo_nxt = os_act(r_tcr[10:9], r_tmo);
      end
      if (w_wr_tcnt) w_tcnt_nxt = bus.i_datain;
      if (w_wr_tcr)  w_tcr_nxt  = bus.i_datain[12:0];
    end

    always_ff @(posedge i_clk_sys) begin
      if (!i_rst_n) begin
        r_tcnt      <= '0;
        r_tcora     <= '1;
        r_tcorb     <= '1;
        r_tcr       <= '0;
        r_cmfa      <= 1'b0;
        r_cmfb      <= 1'b0;
        r_ovf       <= 1'b0;
        r_tmo       <= 1'b0;
        r_irq       <= 1'b0;
        r_ovf_pulse <= 1'b0;
        r_sync      <= '0;
      end else begin
        r_tcnt <= w_tcnt_nxt;
        if (w_wr_tcora) r_tcora <= bus.i_datain;
        if (w_wr_tcorb) r_tcorb <= bus.i_datain;
        r_tcr       <= w_tcr_nxt;
        // W1C with hardware set taking priority
        r_cmfa      <= w_cmfa_set | (r_cmfa & ~(w_wr_tcsr & bus.i_datain[0]));
        r_cmfb      <= w_cmfb_set | (r_cmfb & ~(w_wr_tcsr & bus.i_datain[1]));
        r_ovf       <= w_ovf_set  | (r_ovf  & ~(w_wr_tcsr & bus.i_datain[2]));
        r_tmo       <= w_tmo_nxt;
        r_irq       <= (r_cmfa & r_tcr[6]) | (r_cmfb & r_tcr[7]) | (r_ovf & r_tcr[8]);
        r_ovf_pulse <= w_ovf_set;
        r_sync      <= {r_sync[1:0], i_tmci[c]};
      end
    end

    always_comb begin
      w_rd = '0;
      case (w_reg)
        3'd0:    w_rd = r_tcnt;
        3'd1:    w_rd = r_tcora;
        3'd2:    w_rd = r_tcorb;
        3'd3:    w_rd = CNT_W'(r_tcr);
        3'd4:    w_rd = CNT_W'({r_tmo, r_ovf, r_cmfb, r_cmfa});
        default: w_rd = '0;
      endcase
    end

    assign w_rd_ch[c]     = w_rd;
    assign w_ovf_pulse[c] = r_ovf_pulse;
    assign o_tmo[c]       = r_tmo;
    assign o_irq[c]       = r_irq;
  end
endmodule

// File: doc/tmr_multi_ch.md
Name: tmr_multi_ch

Overview:
Parametrised successor of the 8-bit dual-channel timer: NUM_CH independent CNT_W-bit up-counters with an internal prescaler, external-clock and cascade clock sources, two compare registers each, and per-channel waveform output and level interrupt. The prescaler taps are generated inside the block rather than supplied as separate inputs. A one-shot mode is added. The block sits on the peripheral register bus beside the existing timer and drives interrupt-controller and pin-mux inputs.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 16, counter/compare/bus data width (16..32)
ADDR_W, 6, byte-independent register address width; must satisfy ADDR_W >= 3 + clog2(NUM_CH)

Ports:
i_clk_sys  in  1  system clock, all logic rising-edge
i_rst_n  in  1  synchronous active-low reset
i_wren  in  1  register write strobe, one write per cycle
i_addr  in  ADDR_W  register address: [ADDR_W-1:3]=channel, [2:0]=register
i_datain  in  CNT_W  write data
i_tmci  in  NUM_CH  external count inputs, asynchronous
o_rdata  out  CNT_W  combinational read data for i_addr
o_tmo  out  NUM_CH  waveform outputs
o_irq  out  NUM_CH  level interrupts

Behaviour:
- Register map per channel: 0 TCNT (rw), 1 TCORA (rw), 2 TCORB (rw), 3 TCR (rw), 4 TCSR (flags W1C, TMO ro), 5-7 reserved. Channel index >= NUM_CH is unmapped: reads 0, writes ignored.
- Reset values: TCNT=0, TCORA=TCORB=all-ones, TCR=0, TCSR=0, prescaler=0, sync flops=0, o_tmo=0, o_irq=0.
- TCR fields:
  - [2:0] CKS: 000 stop; 001 /2; 010 /8; 011 /64; 100 /1024; 101 /8192; 110 external rising edge; 111 cascade on overflow of channel ch-1 (channel 0: stop).
  - [4:3] CCLR: 00 none; 01 clear on A; 10 clear on B; 11 none.
  - [5] ONESHOT; [6] CMIEA; [7] CMIEB; [8] OVIE.
  - [10:9] OSA and [12:11] OSB: 00 none, 01 drive 0, 10 drive 1, 11 toggle.
  - Unused bits read 0.
- TCSR fields: [0] CMFA; [1] CMFB; [2] OVF; [3] TMO (read-only mirror of o_tmo).
- Prescaler: free-running 13-bit counter. The /N tick is a one-cycle pulse when the low log2(N) bits are all ones, i.e. every N cycles.
- External clock: i_tmci passes through a 2-flop synchroniser, then rising-edge detection. The tick occurs 3 cycles after the pin rises. The pin must stay high and low for at least 2 cycles each.
- Cascade: the cascade tick is channel ch-1's registered overflow pulse, asserted the cycle after that channel wraps.
- Tick processing, evaluated on the current TCNT in a tick cycle:
  - matchA = (TCNT==TCORA); matchB = (TCNT==TCORB).
  - Next TCNT is 0 if (CCLR=01 & matchA) or (CCLR=10 & matchB) or (ONESHOT & matchA). Otherwise TCNT+1, wrapping modulo 2^CNT_W.
  - Wrap from all-ones without a clear sets OVF and pulses the overflow for the next cycle. A clear takes precedence, so no OVF is raised.
  - matchA sets CMFA; matchB sets CMFB.
- ONESHOT: on matchA, the counter clears and hardware writes TCR[2:0]=000. The counter then stays at 0 until software rewrites CKS.
- o_tmo updates on the cycle after a match, registered. When A and B match on the same tick, the B action wins.
- o_irq = |(CMFA&CMIEA, CMFB&CMIEB, OVF&OVIE). It is registered: asserts 1 cycle after the flag sets and deasserts 1 cycle after the flag clears.
- Write precedence:
  - A bus write to TCNT overrides tick increment or clear in the same cycle; no match is evaluated that cycle.
  - TCSR write of 1 clears a flag, but a hardware set in the same cycle wins. A write of 0 has no effect.
  - A TCR write in the same cycle as a one-shot CKS clear: the bus write wins.
- Compare registers take effect on the cycle after the write.
- Reset asserted mid-count returns everything to reset values on the next edge. In-flight synchroniser edges and overflow pulses are discarded.

Test Plan:
1. Ch0: TCORA=0x0004, TCR=CCLR01|CKS001|CMIEA, all other registers at reset -> TCNT sequence 0,1,2,3,4,0 with increments every 2 cycles; CMFA=1 after TCNT=4 tick; o_irq[0]=1 one cycle later; TCSR write 0x1 -> o_irq[0]=0 one cycle after the write.
2. Ch1: TCNT written 0xFFFE, CKS001, OVIE=1 -> after 2 ticks TCNT=0x0000, OVF=1, o_irq[1]=1. Ch2 set to CKS111 -> ch2 TCNT increments 0->1 one cycle after the ch1 wrap.
3. Ch0: OSA=10, OSB=01, TCORA=3, TCORB=6, CCLR=10, CKS001 -> o_tmo[0] high after TCNT=3, low after 6, with period 14 cycles. TCORA=TCORB=3 -> o_tmo stays 0 (B wins).
4. Ch3: ONESHOT=1, TCORA=5, CKS001 -> counts to 5, clears to 0, TCR[2:0] reads 000, TCNT stays 0 for 50 cycles; rewriting CKS001 restarts counting.
5. Ch0: CKS110, i_tmci[0] pulsed 3 times (4 cycles high, 4 low) -> TCNT=3; first increment observed 3 cycles after the first rising edge.
6. Same-cycle CMFA hardware set and W1C write -> CMFA remains 1. TCNT write 0x0100 coinciding with a tick -> TCNT=0x0100. i_rst_n low mid-count -> all registers and outputs at reset values on the next edge; read of unmapped channel 7 (NUM_CH=4) returns 0.
